// File: rtl/apb2axi_axi_issuer_pkg.sv
// Shared types for the APB-to-AXI bridge: the packed command/response FIFO entries,
// the issuer state encoding and the AXI response codes.
package apb2axi_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef struct packed {
        logic                  is_write;
        logic [ADDR_W-1:0]     addr;
        logic [DATA_W-1:0]     wdata;
        logic [DATA_W/8-1:0]   wstrb;
    } cmd_entry_t;

    typedef struct packed {
        logic                  is_write;
        logic [1:0]            resp;
        logic [DATA_W-1:0]     rdata;
    } rsp_entry_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        RSP     = 3'd5
    } issuer_state_e;
endpackage

// File: rtl/apb2axi_axi_issuer_if.sv
// Bus bundle around the issuer: command FIFO pop side, single-beat AXI channels and
// response FIFO push side. master = issuer, slave = FIFOs plus AXI target.
interface apb2axi_axi_issuer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;
    localparam int CMD_W  = 1 + ADDR_W + DATA_W + STRB_W;
    localparam int RSP_W  = 1 + 2 + DATA_W;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [CMD_W-1:0]  cmd_data;

    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [RSP_W-1:0]  rsp_data;

    modport master (
        input  cmd_valid, cmd_data,
        output cmd_ready,
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  awready, wready, bresp, bvalid,
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid,
        output rsp_valid, rsp_data,
        input  rsp_ready
    );

    modport slave (
        output cmd_valid, cmd_data,
        input  cmd_ready,
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output awready, wready, bresp, bvalid,
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid,
        input  rsp_valid, rsp_data,
        output rsp_ready
    );
endinterface

// File: rtl/apb2axi_axi_issuer.sv
// Pops one command at a time, issues it as a single-beat AXI read or write and pushes
// one response entry back; a single transaction is ever outstanding.
//
// state   | meaning
// IDLE    | cmd_ready high, waiting for a command
// WR_REQ  | AW and W offered independently until both have handshaken
// WR_RESP | bready high, waiting for the B beat
// RD_REQ  | arvalid high until arready
// RD_RESP | rready high, waiting for the R beat
// RSP     | response entry offered until rsp_ready
module apb2axi_axi_issuer #(
    parameter int ADDR_W = apb2axi_pkg::ADDR_W,
    parameter int DATA_W = apb2axi_pkg::DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    apb2axi_axi_issuer_if.master  bus,
    output logic                  busy,
    output logic [7:0]            err_cnt
);
    import apb2axi_pkg::*;

    localparam int STRB_W = DATA_W / 8;
    localparam int CMD_W  = 1 + ADDR_W + DATA_W + STRB_W;
    localparam int RSP_W  = 1 + 2 + DATA_W;

    issuer_state_e     r_state, w_state_nxt;

    logic              r_awvalid, w_awvalid_nxt;
    logic              r_wvalid, w_wvalid_nxt;
    logic              r_bready, w_bready_nxt;
    logic              r_arvalid, w_arvalid_nxt;
    logic              r_rready, w_rready_nxt;
    logic              r_rsp_valid, w_rsp_valid_nxt;
    logic              r_aw_done, w_aw_done_nxt;
    logic              r_w_done, w_w_done_nxt;
    logic [ADDR_W-1:0] r_awaddr, w_awaddr_nxt;
    logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
    logic [STRB_W-1:0] r_wstrb, w_wstrb_nxt;
    logic [ADDR_W-1:0] r_araddr, w_araddr_nxt;
    logic [RSP_W-1:0]  r_rsp_data, w_rsp_data_nxt;
    logic [7:0]        r_err_cnt, w_err_cnt_nxt;

    logic              w_resp_fire;
    logic [1:0]        w_resp_code;

    logic              w_cmd_is_write;
    logic [ADDR_W-1:0] w_cmd_addr;
    logic [DATA_W-1:0] w_cmd_wdata;
    logic [STRB_W-1:0] w_cmd_wstrb;

    assign w_cmd_is_write = bus.cmd_data[CMD_W-1];
    assign w_cmd_addr     = bus.cmd_data[CMD_W-2 -: ADDR_W];
    assign w_cmd_wdata    = bus.cmd_data[STRB_W +: DATA_W];
    assign w_cmd_wstrb    = bus.cmd_data[STRB_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_awvalid_nxt   = r_awvalid;
        w_wvalid_nxt    = r_wvalid;
        w_bready_nxt    = r_bready;
        w_arvalid_nxt   = r_arvalid;
        w_rready_nxt    = r_rready;
        w_rsp_valid_nxt = r_rsp_valid;
        w_aw_done_nxt   = r_aw_done;
        w_w_done_nxt    = r_w_done;
        w_awaddr_nxt    = r_awaddr;
        w_wdata_nxt     = r_wdata;
        w_wstrb_nxt     = r_wstrb;
        w_araddr_nxt    = r_araddr;
        w_rsp_data_nxt  = r_rsp_data;
        w_err_cnt_nxt   = r_err_cnt;
        w_resp_fire     = 1'b0;
        w_resp_code     = AXI_RESP_OKAY;

        unique case (r_state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (w_cmd_is_write) begin
                        w_state_nxt   = WR_REQ;
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                        w_aw_done_nxt = 1'b0;
                        w_w_done_nxt  = 1'b0;
                        w_awaddr_nxt  = w_cmd_addr;
                        w_wdata_nxt   = w_cmd_wdata;
                        w_wstrb_nxt   = w_cmd_wstrb;
                    end else begin
                        w_state_nxt   = RD_REQ;
                        w_arvalid_nxt = 1'b1;
                        w_araddr_nxt  = w_cmd_addr;
                    end
                end
            end
            WR_REQ: begin
                if (r_awvalid && bus.awready) begin
                    w_awvalid_nxt = 1'b0;
                    w_aw_done_nxt = 1'b1;
                end
                if (r_wvalid && bus.wready) begin
                    w_wvalid_nxt = 1'b0;
                    w_w_done_nxt = 1'b1;
                end
                // Same-cycle AW/W completion is seen through the next-state flags.
                if (w_aw_done_nxt && w_w_done_nxt) begin
                    w_state_nxt  = WR_RESP;
                    w_bready_nxt = 1'b1;
                end
            end
            WR_RESP: begin
                if (bus.bvalid) begin
                    w_state_nxt     = RSP;
                    w_bready_nxt    = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_data_nxt  = {1'b1, bus.bresp, {DATA_W{1'b0}}};
                    w_resp_fire     = 1'b1;
                    w_resp_code     = bus.bresp;
                end
            end
            RD_REQ: begin
                if (bus.arready) begin
                    w_state_nxt   = RD_RESP;
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                end
            end
            RD_RESP: begin
                if (bus.rvalid) begin
                    w_state_nxt     = RSP;
                    w_rready_nxt    = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_data_nxt  = {1'b0, bus.rresp, bus.rdata};
                    w_resp_fire     = 1'b1;
                    w_resp_code     = bus.rresp;
                end
            end
            RSP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt     = IDLE;
                    w_rsp_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_resp_fire && (w_resp_code != AXI_RESP_OKAY) && (r_err_cnt != 8'hFF)) begin
            w_err_cnt_nxt = r_err_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_awaddr    <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_araddr    <= '0;
            r_rsp_data  <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_awvalid   <= w_awvalid_nxt;
            r_wvalid    <= w_wvalid_nxt;
            r_bready    <= w_bready_nxt;
            r_arvalid   <= w_arvalid_nxt;
            r_rready    <= w_rready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_aw_done   <= w_aw_done_nxt;
            r_w_done    <= w_w_done_nxt;
            r_awaddr    <= w_awaddr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_wstrb     <= w_wstrb_nxt;
            r_araddr    <= w_araddr_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_err_cnt   <= w_err_cnt_nxt;
        end
    end

    assign bus.cmd_ready = (r_state == IDLE);
    assign busy          = (r_state != IDLE);
    assign err_cnt       = r_err_cnt;

    assign bus.awaddr    = r_awaddr;
    assign bus.awvalid   = r_awvalid;
    assign bus.wdata     = r_wdata;
    assign bus.wstrb     = r_wstrb;
    assign bus.wvalid    = r_wvalid;
    assign bus.bready    = r_bready;
    assign bus.araddr    = r_araddr;
    assign bus.arvalid   = r_arvalid;
    assign bus.rready    = r_rready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
endmodule

// File: doc/apb2axi_axi_issuer.md
Name: apb2axi_axi_issuer

Overview:
- Downstream consumer of the APB-side command FIFO. Pops one packed command (read or write) at a time and issues it as a single-beat AXI transaction on the AW/W/B or AR/R channels.
- Pushes one packed response entry per command into the response FIFO, which returns it to the APB side.
- One transaction outstanding at a time; no bursts.

Parameters:
- ADDR_W, 32, AXI address width
- DATA_W, 32, AXI data width (multiple of 8)
- CMD_W, 1+ADDR_W+DATA_W+DATA_W/8, command entry width (derived, not overridable)
- RSP_W, 1+2+DATA_W, response entry width (derived)

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command FIFO pop_valid
- cmd_ready  out  1  command FIFO pop_ready
- cmd_data  in  CMD_W  {is_write, addr, wdata, wstrb}, MSB first
- awaddr  out  ADDR_W  write address
- awvalid  out  1  AW valid
- awready  in  1  AW ready
- wdata  out  DATA_W  write data
- wstrb  out  DATA_W/8  write strobes
- wvalid  out  1  W valid
- wready  in  1  W ready
- bresp  in  2  write response
- bvalid  in  1  B valid
- bready  out  1  B ready
- araddr  out  ADDR_W  read address
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rdata  in  DATA_W  read data
- rresp  in  2  read response
- rvalid  in  1  R valid
- rready  out  1  R ready
- rsp_valid  out  1  response FIFO push_valid
- rsp_ready  in  1  response FIFO push_ready
- rsp_data  out  RSP_W  {is_write, resp[1:0], rdata}; rdata=0 for writes
- busy  out  1  state != IDLE
- err_cnt  out  8  count of non-OKAY responses, saturates at 255

Behaviour:
- Reset (async, active-high): state=IDLE. All AXI valids/readies=0, rsp_valid=0, addr/data/strb/rsp_data regs=0, err_cnt=0, busy=0. Asserting reset mid-transaction drops all valids immediately; the in-flight command is lost.
- cmd_ready = (state==IDLE), combinational from the state register only.
- Command capture: cmd_valid&&cmd_ready in cycle T latches the fields. In T+1:
  - write: awvalid=wvalid=1;
  - read: arvalid=1.
- States:
  - IDLE: on accept -> WR_REQ (is_write=1) or RD_REQ (is_write=0).
  - WR_REQ: AW and W are independent. awvalid drops the cycle after its own handshake; wvalid likewise. Sticky flags aw_done and w_done track each. When both are done (including same-cycle handshakes) -> WR_RESP. awaddr, wdata and wstrb stay stable while their valid is high.
  - WR_RESP: bready=1. On bvalid, capture bresp -> RSP.
  - RD_REQ: arvalid held until arready -> RD_RESP.
  - RD_RESP: rready=1. On rvalid, capture rresp and rdata -> RSP.
  - RSP: rsp_valid=1 with rsp_data stable until rsp_ready; then -> IDLE.
- bready and rready are asserted only in WR_RESP and RD_RESP respectively, never in IDLE. Early B or R beats are therefore held off by the slave.
- Valids never deassert without a handshake (AXI rule).
- Minimum latency: accept at T, AW/W handshake at T+1, B at T+2, rsp_valid at T+3, cmd_ready at T+4 if rsp_ready=1. Back-to-back throughput is therefore one command per 4 cycles minimum.
- Backpressure: if rsp_ready=0, hold RSP indefinitely; no new command is accepted.
- err_cnt increments by 1 on each captured resp != 2'b00 (SLVERR/DECERR/EXOKAY all count). It saturates at 8'hFF and never wraps.
- All outputs are registered except cmd_ready and busy, which are decoded from state.

Decomposition:
- Package apb2axi_pkg holds:
  - ADDR_W, DATA_W;
  - typedef cmd_entry_t, a packed struct {is_write, addr, wdata, wstrb};
  - typedef rsp_entry_t, a packed struct {is_write, resp, rdata};
  - typedef issuer_state_e {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP};
  - localparams AXI_RESP_OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11.
- No sub-module: a single FSM plus datapath registers. The command and response FIFOs are instantiated by the parent, not inside this block.

Test Plan:
- Write, slave always ready: cmd {1, 0x1000, 0xDEADBEEF, 0xF} -> awaddr=0x1000, wdata=0xDEADBEEF, wstrb=0xF with AW/W handshakes 1 cycle after accept; bresp=OKAY -> rsp_data={1, 00, 0}, err_cnt=0.
- Skewed write channels: awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held stable 3 cycles, bready asserted only after both handshakes; single response pushed.
- Read with error: cmd {0, 0x2004} -> araddr=0x2004; rvalid with rdata=0x12345678, rresp=SLVERR -> rsp_data={0, 10, 0x12345678}, err_cnt=1.
- Response backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stable, cmd_ready=0 throughout; release -> IDLE next cycle, next command accepted.
- Saturation and back-to-back: 260 DECERR writes -> err_cnt stops at 255; the interval between consecutive cmd accepts is ≥4 cycles.
- Reset mid-op: assert rst while in WR_REQ with awvalid=1 -> awvalid/wvalid=0 immediately (asynchronous), busy=0, err_cnt=0; after deassert, the next command completes normally.
